perip_arbiter: RTL and testbench
================================

PERIP_ARBITER -- requirements
Module: perip_arbiter

Interface
REQ-001 Parameter RD_LAT, default 1, SHALL be the cycles from read issue to valid perip_rdata (legal 1..4).
REQ-002 Parameter RR_MODE, default 1, SHALL select round-robin (1) or fixed priority with m0 winning (0).
REQ-003 cpu_clk  in  1  SHALL be the single clock; all state is rising-edge.
REQ-004 cpu_rst  in  1  SHALL be the reset: asynchronous, active-low.
REQ-005 m0_req/m1_req  in  1  SHALL be the per-master request, held with its payload until granted.
REQ-006 m0_addr/m1_addr  in  32  SHALL be the request address.
REQ-007 m0_wen/m1_wen  in  1  SHALL select a write (1) or a read (0).
REQ-008 m0_mask/m1_mask  in  2  SHALL be the access size code, passed through unchanged.
REQ-009 m0_wdata/m1_wdata  in  32  SHALL be the write data.
REQ-010 m0_gnt/m1_gnt  out  1  SHALL be asserted in the cycle the request is issued to the bus.
REQ-011 m0_rvalid/m1_rvalid  out  1  SHALL be a one-cycle read-return pulse.
REQ-012 m0_rdata/m1_rdata  out  32  SHALL be the registered read data, valid while rvalid is high.
REQ-013 perip_addr/perip_wen/perip_mask/perip_wdata  out  32/1/2/32  SHALL be the shared peripheral bus.
REQ-014 perip_rdata  in  32  SHALL be the peripheral read data.
REQ-015 busy  out  1  SHALL be high whenever the FSM is in WAIT.

Function
REQ-016 The FSM SHALL have two states, IDLE and WAIT; the state SHALL be IDLE after reset.
REQ-017 IDLE with no request: perip_wen=0, perip_addr=0, perip_mask=0, perip_wdata=0, all gnt=0.
REQ-018 IDLE with a request: the winner's payload SHALL drive the perip bus combinationally and the winner's gnt SHALL be 1 in the same cycle; the loser's gnt SHALL be 0.
REQ-019 A granted write SHALL complete in the grant cycle; the FSM SHALL stay in IDLE, so one write per cycle is sustainable.
REQ-020 A granted read SHALL latch owner, addr and mask, load a counter with RD_LAT and enter WAIT.
REQ-021 WAIT: perip_wen=0, perip_addr/perip_mask SHALL hold the latched values, perip_wdata=0, no gnt; the counter decrements each cycle.
REQ-022 Read issued in cycle T: perip_rdata SHALL be sampled at the end of cycle T+RD_LAT, the FSM SHALL return to IDLE, and the owner's rvalid SHALL pulse in cycle T+RD_LAT+1.
REQ-023 A new grant SHALL be possible in cycle T+RD_LAT+1, concurrent with the rvalid pulse.
REQ-024 m*_rdata SHALL hold its last value when not valid; rvalid SHALL go only to the read owner.
REQ-025 RR_MODE=1 with simultaneous requests: the master not granted most recently SHALL win; the last-grant pointer SHALL update on every grant, read or write.
REQ-026 RR_MODE=1 with a single requester: that requester SHALL be granted regardless of the pointer.
REQ-027 RR_MODE=0: m0 SHALL always win a conflict; m1 may starve, which is accepted.
REQ-028 Requests arriving during WAIT SHALL be held off (gnt=0) and arbitrated in the first IDLE cycle.
REQ-029 A request deasserted before grant SHALL be dropped without any bus activity.

Reset
REQ-030 Asserting cpu_rst low SHALL immediately force IDLE, all gnt/rvalid/busy=0, perip outputs 0, rdata registers 0, counter 0, and the pointer to "m1 last" so m0 wins the first conflict.
REQ-031 Reset during WAIT SHALL abort the read with no rvalid; perip_rdata is ignored until the next grant.
REQ-032 After reset is released, the first grant SHALL occur no earlier than the first rising edge with cpu_rst high.

Verification
REQ-033 The bench SHALL cover: m0 write addr=0x8020_0000, wdata=0x1234_5678 -> m0_gnt=1 and perip_wen=1 with that addr/data in the same cycle; the next cycle is IDLE.
REQ-034 The bench SHALL cover: RD_LAT=2, m1 read of 0x8020_0010 with perip_rdata=0xCAFE_F00D at T+2 -> m1_rvalid=1 at T+3 with m1_rdata=0xCAFE_F00D; busy=1 during T+1..T+2.
REQ-035 The bench SHALL cover: RR_MODE=1, both masters issue continuous writes -> grants alternate m0,m1,m0,m1 starting with m0 after reset.
REQ-036 The bench SHALL cover: RR_MODE=0, both request -> m0 is granted every cycle and m1_gnt stays 0.
REQ-037 The bench SHALL cover: m0 read in flight while m1 requests a write -> m1_gnt=0 during WAIT and m1_gnt=1 in the same cycle as m0_rvalid.
REQ-038 The bench SHALL cover: cpu_rst pulsed low mid-WAIT (RD_LAT=4, one cycle after issue) -> no rvalid, busy=0 asynchronously, and normal grants after release.

Source files
------------

// File: rtl/perip_arbiter.sv
// -----------------------------------------------------------------------------
// perip_arbiter
//   Two-master arbiter in front of a single peripheral bus. Writes complete in
//   the grant cycle; reads hold the bus for RD_LAT cycles and return data to
//   the issuing master as a one-cycle rvalid pulse with registered rdata.
//
// Parameters
//   RD_LAT   cycles from read issue to valid perip_rdata (1..4)
//   RR_MODE  1: round-robin on conflict, 0: fixed priority (m0 wins)
//
// Ports
//   cpu_clk, cpu_rst          clock, asynchronous active-low reset
//   m{0,1}_req/addr/wen/mask/wdata   master request and payload
//   m{0,1}_gnt                request issued to the bus this cycle
//   m{0,1}_rvalid/rdata       read-return pulse and held read data
//   perip_addr/wen/mask/wdata shared peripheral bus
//   perip_rdata               peripheral read data
//   busy                      read in flight
// -----------------------------------------------------------------------------
module perip_arbiter #(
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned RR_MODE = 1
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic        m0_wen,
  input  logic [1:0]  m0_mask,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic        m1_wen,
  input  logic [1:0]  m1_mask,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic [31:0] perip_addr,
  output logic        perip_wen,
  output logic [1:0]  perip_mask,
  output logic [31:0] perip_wdata,
  input  logic [31:0] perip_rdata,
  output logic        busy
);

  localparam int unsigned CNT_W = 3;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned MW    = 2;
  localparam logic        RR_EN = (RR_MODE != 0);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             owner_q, owner_d;     // 1: m1 owns the read in flight
  logic [AW-1:0]    addr_q, addr_d;
  logic [MW-1:0]    mask_q, mask_d;
  logic             last_m1_q, last_m1_d; // 1: m1 was granted most recently
  logic             rd_done;

  logic             m0_rvalid_q, m1_rvalid_q;
  logic [DW-1:0]    m0_rdata_q, m1_rdata_q;

  logic             req_any_c;
  logic             sel_m1_c;
  logic             sel_wen_c;
  logic [AW-1:0]    sel_addr_c;
  logic [MW-1:0]    sel_mask_c;
  logic [DW-1:0]    sel_wdata_c;

  // Arbitration: pick the winner and mux its payload.
  always_comb begin
    req_any_c = m0_req | m1_req;
    if (m0_req && m1_req) begin
      // On conflict, round-robin hands the bus to whoever did not go last.
      sel_m1_c = RR_EN & ~last_m1_q;
    end else begin
      sel_m1_c = m1_req;
    end
    sel_wen_c   = sel_m1_c ? m1_wen   : m0_wen;
    sel_addr_c  = sel_m1_c ? m1_addr  : m0_addr;
    sel_mask_c  = sel_m1_c ? m1_mask  : m0_mask;
    sel_wdata_c = sel_m1_c ? m1_wdata : m0_wdata;
  end

  // Next-state and bus outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    mask_d      = mask_q;
    last_m1_d   = last_m1_q;
    rd_done     = 1'b0;
    m0_gnt      = 1'b0;
    m1_gnt      = 1'b0;
    perip_wen   = 1'b0;
    perip_addr  = '0;
    perip_mask  = '0;
    perip_wdata = '0;

    case (state_q)
      IDLE: begin
        // Gating with cpu_rst keeps the bus quiet while reset is asserted.
        if (cpu_rst && req_any_c) begin
          m0_gnt      = ~sel_m1_c;
          m1_gnt      = sel_m1_c;
          perip_wen   = sel_wen_c;
          perip_addr  = sel_addr_c;
          perip_mask  = sel_mask_c;
          perip_wdata = sel_wdata_c;
          last_m1_d   = sel_m1_c;
          if (!sel_wen_c) begin
            state_d = WAIT;
            cnt_d   = CNT_W'(RD_LAT);
            owner_d = sel_m1_c;
            addr_d  = sel_addr_c;
            mask_d  = sel_mask_c;
          end
        end
      end
      WAIT: begin
        perip_addr = addr_q;
        perip_mask = mask_q;
        cnt_d      = cnt_q - CNT_W'(1);
        // Last WAIT cycle: perip_rdata is captured at the closing edge.
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          rd_done = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state.
  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      owner_q   <= 1'b0;
      addr_q    <= '0;
      mask_q    <= '0;
      last_m1_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      mask_q    <= mask_d;
      last_m1_q <= last_m1_d;
    end
  end

  // Read return: pulse rvalid to the owner only, rdata holds otherwise.
  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      m0_rvalid_q <= rd_done & ~owner_q;
      m1_rvalid_q <= rd_done & owner_q;
      if (rd_done && !owner_q) begin
        m0_rdata_q <= perip_rdata;
      end
      if (rd_done && owner_q) begin
        m1_rdata_q <= perip_rdata;
      end
    end
  end

  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign busy      = (state_q == WAIT);

endmodule

// File: tb/tb_perip_arbiter.sv
// -----------------------------------------------------------------------------
// tb_perip_arbiter
//   Three arbiter instances share one stimulus stream:
//     u0: RD_LAT=2, round-robin   u1: RD_LAT=1, fixed priority
//     u2: RD_LAT=4, round-robin
//   Directed scenarios check fixed expected values; a random phase compares
//   every output of every instance to a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_perip_arbiter;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic        m0_req, m1_req, m0_wen, m1_wen;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [1:0]  m0_mask, m1_mask;
  logic [31:0] perip_rdata;

  logic        g0 [3];
  logic        g1 [3];
  logic        rv0 [3];
  logic        rv1 [3];
  logic        bsy [3];
  logic        pwen [3];
  logic [31:0] rd0 [3];
  logic [31:0] rd1 [3];
  logic [31:0] paddr [3];
  logic [31:0] pwd [3];
  logic [1:0]  pmask [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 cpu_clk = ~cpu_clk;

  perip_arbiter #(.RD_LAT(2), .RR_MODE(1)) u0 (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wen(m0_wen), .m0_mask(m0_mask), .m0_wdata(m0_wdata),
    .m0_gnt(g0[0]), .m0_rvalid(rv0[0]), .m0_rdata(rd0[0]),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wen(m1_wen), .m1_mask(m1_mask), .m1_wdata(m1_wdata),
    .m1_gnt(g1[0]), .m1_rvalid(rv1[0]), .m1_rdata(rd1[0]),
    .perip_addr(paddr[0]), .perip_wen(pwen[0]), .perip_mask(pmask[0]), .perip_wdata(pwd[0]),
    .perip_rdata(perip_rdata), .busy(bsy[0]));

  perip_arbiter #(.RD_LAT(1), .RR_MODE(0)) u1 (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wen(m0_wen), .m0_mask(m0_mask), .m0_wdata(m0_wdata),
    .m0_gnt(g0[1]), .m0_rvalid(rv0[1]), .m0_rdata(rd0[1]),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wen(m1_wen), .m1_mask(m1_mask), .m1_wdata(m1_wdata),
    .m1_gnt(g1[1]), .m1_rvalid(rv1[1]), .m1_rdata(rd1[1]),
    .perip_addr(paddr[1]), .perip_wen(pwen[1]), .perip_mask(pmask[1]), .perip_wdata(pwd[1]),
    .perip_rdata(perip_rdata), .busy(bsy[1]));

  perip_arbiter #(.RD_LAT(4), .RR_MODE(1)) u2 (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wen(m0_wen), .m0_mask(m0_mask), .m0_wdata(m0_wdata),
    .m0_gnt(g0[2]), .m0_rvalid(rv0[2]), .m0_rdata(rd0[2]),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wen(m1_wen), .m1_mask(m1_mask), .m1_wdata(m1_wdata),
    .m1_gnt(g1[2]), .m1_rvalid(rv1[2]), .m1_rdata(rd1[2]),
    .perip_addr(paddr[2]), .perip_wen(pwen[2]), .perip_mask(pmask[2]), .perip_wdata(pwd[2]),
    .perip_rdata(perip_rdata), .busy(bsy[2]));

  // ---------------- reference model (transaction level) ----------------
  int          busy_left [3];   // bus cycles still reserved by a read
  int          rd_owner [3];
  logic [31:0] rd_addr [3];
  logic [1:0]  rd_mask [3];
  int          last_win [3];    // master granted most recently
  bit          rv_due [3];      // read data returns this cycle
  logic [31:0] ret_data [3][2];

  function automatic int lat_of(int k);
    return (k == 0) ? 2 : (k == 1) ? 1 : 4;
  endfunction

  function automatic bit rr_of(int k);
    return (k != 1);
  endfunction

  // Which master (0/1) owns the bus this cycle, or -1.
  function automatic int exp_win(int k);
    if (!cpu_rst || busy_left[k] > 0) return -1;
    if (m0_req && m1_req) return (rr_of(k) && last_win[k] == 0) ? 1 : 0;
    if (m0_req) return 0;
    if (m1_req) return 1;
    return -1;
  endfunction

  always @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      for (int k = 0; k < 3; k++) begin
        busy_left[k] = 0;
        rd_owner[k]  = 0;
        rd_addr[k]   = '0;
        rd_mask[k]   = '0;
        last_win[k]  = 1;
        rv_due[k]    = 1'b0;
        ret_data[k][0] = '0;
        ret_data[k][1] = '0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        int w;
        w = exp_win(k);
        rv_due[k] = 1'b0;
        if (busy_left[k] > 0) begin
          if (busy_left[k] == 1) begin
            ret_data[k][rd_owner[k]] = perip_rdata;
            rv_due[k] = 1'b1;
          end
          busy_left[k] = busy_left[k] - 1;
        end else if (w >= 0) begin
          last_win[k] = w;
          if (!((w == 0) ? m0_wen : m1_wen)) begin
            busy_left[k] = lat_of(k);
            rd_owner[k]  = w;
            rd_addr[k]   = (w == 0) ? m0_addr : m1_addr;
            rd_mask[k]   = (w == 0) ? m0_mask : m1_mask;
          end
        end
      end
    end
  end

  // ---------------- helpers (stimulus only) ----------------
  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic clear_in();
    m0_req = 0; m1_req = 0; m0_wen = 0; m1_wen = 0;
    m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
    m0_mask = '0; m1_mask = '0; perip_rdata = '0;
  endtask

  task automatic do_reset();
    clear_in();
    @(negedge cpu_clk);
    cpu_rst = 0;
    repeat (2) @(negedge cpu_clk);
    cpu_rst = 1;
    tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clear_in();
    m0_req = 1; m1_req = 1; m0_wen = 1; m1_wen = 1;
    m0_addr = 32'h1111_0000; m0_wdata = 32'h2222_0000; m0_mask = 2'd3;
    cpu_rst = 0;
    repeat (2) @(negedge cpu_clk);
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if ({g0[k], g1[k], rv0[k], rv1[k], bsy[k], pwen[k]} !== 6'b0) begin
        n_fail++;
        $display("FAIL reset_ctrl u%0d: gnt/rvalid/busy/wen=%b required 000000", k,
                 {g0[k], g1[k], rv0[k], rv1[k], bsy[k], pwen[k]});
      end
      n_tests++;
      if (paddr[k] !== 32'h0 || pwd[k] !== 32'h0 || pmask[k] !== 2'd0 ||
          rd0[k] !== 32'h0 || rd1[k] !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_data u%0d: addr=%h wdata=%h mask=%0d rd0=%h rd1=%h required all 0",
                 k, paddr[k], pwd[k], pmask[k], rd0[k], rd1[k]);
      end
    end
    do_reset();
  endtask

  task automatic test_write();
    do_reset();
    m0_req = 1; m0_wen = 1; m0_addr = 32'h8020_0000; m0_wdata = 32'h1234_5678; m0_mask = 2'd2;
    @(negedge cpu_clk);
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (g0[k] !== 1'b1 || g1[k] !== 1'b0 || pwen[k] !== 1'b1 || paddr[k] !== 32'h8020_0000 ||
          pwd[k] !== 32'h1234_5678 || pmask[k] !== 2'd2) begin
        n_fail++;
        $display("FAIL write_grant u%0d: gnt=%b%b wen=%b addr=%h wdata=%h mask=%0d required 10 1 80200000 12345678 2",
                 k, g0[k], g1[k], pwen[k], paddr[k], pwd[k], pmask[k]);
      end
    end
    tick();
    clear_in();
    @(negedge cpu_clk);
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (bsy[k] !== 1'b0 || pwen[k] !== 1'b0 || paddr[k] !== 32'h0) begin
        n_fail++;
        $display("FAIL write_idle u%0d: busy=%b wen=%b addr=%h required 0 0 0", k, bsy[k], pwen[k], paddr[k]);
      end
    end
    tick();
  endtask

  task automatic test_read_lat2();
    do_reset();
    m1_req = 1; m1_wen = 0; m1_addr = 32'h8020_0010; m1_mask = 2'd1;
    @(negedge cpu_clk);  // cycle T
    n_tests++;
    if (g1[0] !== 1'b1 || pwen[0] !== 1'b0 || paddr[0] !== 32'h8020_0010) begin
      n_fail++;
      $display("FAIL read_issue: gnt1=%b wen=%b addr=%h required 1 0 80200010", g1[0], pwen[0], paddr[0]);
    end
    tick();
    clear_in();
    @(negedge cpu_clk);  // T+1
    n_tests++;
    if (bsy[0] !== 1'b1 || paddr[0] !== 32'h8020_0010 || pmask[0] !== 2'd1 || g1[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL read_wait1: busy=%b addr=%h mask=%0d gnt1=%b required 1 80200010 1 0",
               bsy[0], paddr[0], pmask[0], g1[0]);
    end
    tick();
    perip_rdata = 32'hCAFE_F00D;
    @(negedge cpu_clk);  // T+2
    n_tests++;
    if (bsy[0] !== 1'b1 || rv1[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL read_wait2: busy=%b rvalid1=%b required 1 0", bsy[0], rv1[0]);
    end
    tick();
    perip_rdata = 32'h0;
    @(negedge cpu_clk);  // T+3
    n_tests++;
    if (rv1[0] !== 1'b1 || rd1[0] !== 32'hCAFE_F00D || rv0[0] !== 1'b0 || bsy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL read_return: rvalid1=%b rdata1=%h rvalid0=%b busy=%b required 1 cafef00d 0 0",
               rv1[0], rd1[0], rv0[0], bsy[0]);
    end
    tick();
    @(negedge cpu_clk);  // T+4
    n_tests++;
    if (rv1[0] !== 1'b0 || rd1[0] !== 32'hCAFE_F00D) begin
      n_fail++;
      $display("FAIL read_hold: rvalid1=%b rdata1=%h required 0 cafef00d", rv1[0], rd1[0]);
    end
    tick();
  endtask

  task automatic test_arbitration();
    do_reset();
    m0_req = 1; m1_req = 1; m0_wen = 1; m1_wen = 1;
    m0_addr = 32'hA000_0000; m1_addr = 32'hB000_0000;
    for (int i = 0; i < 6; i++) begin
      @(negedge cpu_clk);
      n_tests++;
      if (g0[0] !== ((i % 2) == 0) || g1[0] !== ((i % 2) == 1) ||
          paddr[0] !== (((i % 2) == 0) ? 32'hA000_0000 : 32'hB000_0000)) begin
        n_fail++;
        $display("FAIL rr_alternate cyc%0d: gnt=%b%b addr=%h required m%0d", i, g0[0], g1[0], paddr[0], i % 2);
      end
      n_tests++;
      if (g0[1] !== 1'b1 || g1[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL fixed_prio cyc%0d: gnt=%b%b required 10", i, g0[1], g1[1]);
      end
      tick();
    end
    clear_in();
  endtask

  task automatic test_holdoff();
    do_reset();
    m0_req = 1; m0_wen = 0; m0_addr = 32'h8020_0040;
    tick();  // read issued in T
    clear_in();
    m1_req = 1; m1_wen = 1; m1_addr = 32'h8020_0080; m1_wdata = 32'h5555_AAAA;
    for (int i = 1; i <= 2; i++) begin
      @(negedge cpu_clk);
      n_tests++;
      if (g1[0] !== 1'b0 || pwen[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL holdoff T+%0d: gnt1=%b wen=%b required 0 0", i, g1[0], pwen[0]);
      end
      tick();
    end
    @(negedge cpu_clk);  // T+3
    n_tests++;
    if (g1[0] !== 1'b1 || rv0[0] !== 1'b1 || pwd[0] !== 32'h5555_AAAA) begin
      n_fail++;
      $display("FAIL holdoff_release: gnt1=%b rvalid0=%b wdata=%h required 1 1 5555aaaa", g1[0], rv0[0], pwd[0]);
    end
    tick();
    clear_in();
  endtask

  task automatic test_reset_in_wait();
    bit seen_rv;
    do_reset();
    m0_req = 1; m0_wen = 0; m0_addr = 32'h8020_0100;
    tick();
    clear_in();
    #1;  // cycle T+1
    n_tests++;
    if (bsy[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_pre: busy=%b required 1", bsy[2]);
    end
    cpu_rst = 0;
    #1;
    n_tests++;
    if (bsy[2] !== 1'b0 || bsy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_async: busy u2=%b u0=%b required 0 0", bsy[2], bsy[0]);
    end
    #1;
    cpu_rst = 1;
    perip_rdata = 32'hDEAD_BEEF;
    seen_rv = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge cpu_clk);
      if (rv0[2] !== 1'b0 || rv1[2] !== 1'b0 || bsy[2] !== 1'b0) seen_rv = 1;
      tick();
    end
    n_tests++;
    if (seen_rv) begin
      n_fail++;
      $display("FAIL abort_no_rvalid: rvalid/busy seen=1 required 0");
    end
    m1_req = 1; m1_wen = 1; m1_addr = 32'h8020_0200; m1_wdata = 32'h0BAD_CAFE;
    @(negedge cpu_clk);
    n_tests++;
    if (g1[2] !== 1'b1 || pwen[2] !== 1'b1 || paddr[2] !== 32'h8020_0200) begin
      n_fail++;
      $display("FAIL abort_resume: gnt1=%b wen=%b addr=%h required 1 1 80200200", g1[2], pwen[2], paddr[2]);
    end
    tick();
    clear_in();
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      m0_req = ($urandom_range(9, 0) < 6); m1_req = ($urandom_range(9, 0) < 6);
      m0_wen = $urandom_range(1, 0); m1_wen = $urandom_range(1, 0);
      m0_addr = $urandom; m1_addr = $urandom; m0_wdata = $urandom; m1_wdata = $urandom;
      m0_mask = 2'($urandom_range(3, 0)); m1_mask = 2'($urandom_range(3, 0));
      perip_rdata = $urandom;
      if ($urandom_range(99, 0) < 2) begin
        cpu_rst = 0;
        #1;
        cpu_rst = 1;
      end
      @(negedge cpu_clk);
      for (int k = 0; k < 3; k++) begin
        int          w;
        logic [31:0] e_addr, e_wd;
        logic [1:0]  e_mask;
        logic        e_wen;
        w      = exp_win(k);
        e_addr = (busy_left[k] > 0) ? rd_addr[k] : (w == 0) ? m0_addr : (w == 1) ? m1_addr : 32'h0;
        e_mask = (busy_left[k] > 0) ? rd_mask[k] : (w == 0) ? m0_mask : (w == 1) ? m1_mask : 2'd0;
        e_wd   = (w == 0) ? m0_wdata : (w == 1) ? m1_wdata : 32'h0;
        e_wen  = (w == 0) ? m0_wen : (w == 1) ? m1_wen : 1'b0;
        n_tests++;
        if (g0[k] !== (w == 0) || g1[k] !== (w == 1) || bsy[k] !== (busy_left[k] > 0)) begin
          n_fail++;
          $display("FAIL rnd_ctrl c%0d u%0d: gnt=%b%b busy=%b required win=%0d busy=%0d",
                   c, k, g0[k], g1[k], bsy[k], w, busy_left[k] > 0);
        end
        n_tests++;
        if (paddr[k] !== e_addr || pmask[k] !== e_mask || pwd[k] !== e_wd || pwen[k] !== e_wen) begin
          n_fail++;
          $display("FAIL rnd_bus c%0d u%0d: addr=%h mask=%0d wdata=%h wen=%b required %h %0d %h %b",
                   c, k, paddr[k], pmask[k], pwd[k], pwen[k], e_addr, e_mask, e_wd, e_wen);
        end
        n_tests++;
        if (rv0[k] !== (rv_due[k] && rd_owner[k] == 0) || rv1[k] !== (rv_due[k] && rd_owner[k] == 1) ||
            rd0[k] !== ret_data[k][0] || rd1[k] !== ret_data[k][1]) begin
          n_fail++;
          $display("FAIL rnd_ret c%0d u%0d: rv=%b%b rd0=%h rd1=%h required rv_due=%0d own=%0d %h %h",
                   c, k, rv0[k], rv1[k], rd0[k], rd1[k], rv_due[k], rd_owner[k],
                   ret_data[k][0], ret_data[k][1]);
        end
      end
      tick();
    end
    clear_in();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cpu_rst = 1;
    clear_in();
    #2;
    test_reset();
    test_write();
    test_read_lat2();
    test_arbitration();
    test_holdoff();
    test_reset_in_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
